// File: rtl/alu_issue_unit.sv
// ALU issue unit: accepts one instruction, reads operands, drives the ALU, then writes back or branches.
// Define ALU_OVF_TRAP_EN to turn an overflowing write-class result into an illegal_op trap.
module alu_issue_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALU_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              illegal_op,
  output logic [2:0]        flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [31:0]         instr_q;
  logic [DATA_W-1:0]   pc_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q;
  logic [4:0]          alu_op_q;
  logic                wr_en_q, wr_en_d;
  logic                br_taken_q, br_taken_d;
  logic                illegal_q, illegal_d;
  logic [REG_AW-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [DATA_W-1:0]   br_target_q;
  logic [2:0]          flags_q, flags_d;

  logic [4:0]          op_s;
  logic                imm_sel_s;
  logic [REG_AW-1:0]   rd_s;
  logic [15:0]         imm16_s;
  logic                is_branch_s, is_illegal_s, is_write_s, is_cv_s;
  logic                exec_last_s;

  assign op_s         = instr_q[31:27];
  assign imm_sel_s    = instr_q[26];
  assign rd_s         = REG_AW'(instr_q[25:21]);
  assign imm16_s      = instr_q[15:0];
  assign is_branch_s  = (op_s == 5'b00010) || (op_s == 5'b00111) || (op_s == 5'b01010);
  assign is_illegal_s = (op_s == 5'b01101) || (op_s == 5'b01110) || (op_s == 5'b01111);
  assign is_write_s   = !is_branch_s && !is_illegal_s;
  assign is_cv_s      = (op_s == 5'b00000) || (op_s == 5'b00001) || (op_s == 5'b00011);
  assign exec_last_s  = (state_q == S_EXEC) && (cnt_q == 3'd0);

  // Regfile addresses come straight from the offered word while idle so the sync read lines up with READ.
  assign rs_addr     = (state_q == S_IDLE) ? REG_AW'(instr[20:16]) : REG_AW'(instr_q[20:16]);
  assign rt_addr     = (state_q == S_IDLE) ? REG_AW'(instr[15:11]) : REG_AW'(instr_q[15:11]);
  assign instr_ready = (state_q == S_IDLE);

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign br_taken   = br_taken_q;
  assign br_target  = br_target_q;
  assign illegal_op = illegal_q;
  assign flags      = flags_q;

  // Next-state logic and EXEC hold-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_EXEC;
        cnt_d   = 3'(ALU_LAT - 1);
      end
      S_EXEC: begin
        if (cnt_q == 3'd0) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Write-back strobes and flag update, decided from the ALU sample on the last EXEC cycle.
  always_comb begin
    wr_en_d    = 1'b0;
    br_taken_d = 1'b0;
    illegal_d  = 1'b0;
    flags_d    = flags_q;
    if (exec_last_s) begin
      if (is_illegal_s) begin
        illegal_d = 1'b1;
      end else if (is_branch_s) begin
        br_taken_d = alu_zero;
        flags_d[0] = alu_zero;
      end else begin
        flags_d[0] = (alu_out == {DATA_W{1'b0}});
        if (is_cv_s) begin
          flags_d[2:1] = {alu_overflow, alu_carry};
        end else begin
          flags_d[2:1] = flags_q[2:1];
        end
`ifdef ALU_OVF_TRAP_EN
        if (alu_overflow) begin
          illegal_d = 1'b1;
        end else begin
          wr_en_d = (rd_s != {REG_AW{1'b0}});
        end
`else
        wr_en_d = (rd_s != {REG_AW{1'b0}});
`endif
      end
    end else begin
      flags_d = flags_q;
    end
  end

  // Control state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Instruction capture and ALU operand registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q  <= 32'd0;
      pc_q     <= {DATA_W{1'b0}};
      alu_a_q  <= {DATA_W{1'b0}};
      alu_b_q  <= {DATA_W{1'b0}};
      alu_op_q <= 5'd0;
    end else begin
      if ((state_q == S_IDLE) && instr_valid) begin
        instr_q <= instr;
        pc_q    <= pc_in;
      end
      if (state_q == S_READ) begin
        alu_a_q  <= rs_data;
        alu_b_q  <= imm_sel_s ? sext16(imm16_s) : rt_data;
        alu_op_q <= op_s;
      end
    end
  end

  // Registered write-back / branch / trap outputs and flag register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      illegal_q   <= 1'b0;
      wr_addr_q   <= {REG_AW{1'b0}};
      wr_data_q   <= {DATA_W{1'b0}};
      br_target_q <= {DATA_W{1'b0}};
      flags_q     <= 3'd0;
    end else begin
      wr_en_q    <= wr_en_d;
      br_taken_q <= br_taken_d;
      illegal_q  <= illegal_d;
      flags_q    <= flags_d;
      if (exec_last_s && is_write_s) begin
        wr_addr_q <= rd_s;
        wr_data_q <= alu_out;
      end
      if (exec_last_s && is_branch_s) begin
        br_target_q <= pc_q + sext16(imm16_s);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Randomised bench for alu_issue_unit: the bench plays regfile and ALU and predicts every WB outcome.
module tb_alu_issue_unit;

  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_out;
  logic        alu_zero, alu_carry, alu_overflow;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        illegal_op;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] rf [32];
  bit          rf_wr [32];
  logic [31:0] rf_m [32];
  logic [2:0]  flags_m;

  alu_issue_unit #(.DATA_W(32), .REG_AW(5), .ALU_LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc_in(pc_in), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .br_taken(br_taken), .br_target(br_target), .illegal_op(illegal_op), .flags(flags)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input logic [4:0] i);
    case (i)
      5'd0:    return 32'd0;
      5'd1:    return 32'd7;
      5'd2:    return 32'd5;
      5'd5:    return 32'd1;
      5'd6:    return 32'h7FFF_FFFF;
      5'd9:    return 32'd9;
      default: return 32'(i) * 32'h9E37_79B9;
    endcase
  endfunction

  function automatic logic [31:0] rf_rd(input logic [4:0] a);
    return rf_wr[a] ? rf[a] : init_val(a);
  endfunction

  // Environment ALU: returns {overflow, carry, zero, result}.
  function automatic logic [34:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic        v;
    logic        z;
    case (op)
      5'd0: begin s = {1'b0, a} + {1'b0, b};         v = (a[31] == b[31]) && (s[31] != a[31]); end
      5'd1: begin s = {1'b0, a} - {1'b0, b};         v = (a[31] != b[31]) && (s[31] != a[31]); end
      5'd3: begin s = {1'b0, a} + {1'b0, b} + 33'd1; v = (a[31] == b[31]) && (s[31] != a[31]); end
      default: begin s = {^a, a ^ b ^ {27'd0, op}}; v = b[0]; end
    endcase
    if (op == 5'd2)       z = (a == b);
    else if (op == 5'd7)  z = (a != b);
    else if (op == 5'd10) z = 1'b1;
    else                  z = (s[31:0] == 32'd0);
    return {v, s[32], z, s[31:0]};
  endfunction

  assign {alu_overflow, alu_carry, alu_zero, alu_out} = alu_f(alu_opcode, alu_a, alu_b);

  // Synchronous-read register file; r0 ignores writes.
  always @(posedge clock) begin
    rs_data <= rf_rd(rs_addr);
    rt_data <= rf_rd(rt_addr);
    if (wr_en && (wr_addr != 5'd0)) begin
      rf[wr_addr]    <= wr_data;
      rf_wr[wr_addr] <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one instruction and check every cycle until the unit is idle again.
  task automatic do_instr(input logic [31:0] ins, input logic [31:0] pc, input bit noise);
    logic [4:0]  op, rd, rs, rt;
    logic        imm;
    logic [15:0] i16;
    logic [31:0] a, b, res, tgt;
    logic [34:0] r;
    bit          brc, ill, wcls, cv, trap, e_wr, e_br, e_ill;
    logic [2:0]  f_n;
    int          w;
    op  = ins[31:27]; imm = ins[26]; rd = ins[25:21]; rs = ins[20:16];
    rt  = ins[15:11]; i16 = ins[15:0];
    a   = rf_m[rs];
    b   = imm ? {{16{i16[15]}}, i16} : rf_m[rt];
    r   = alu_f(op, a, b);
    res = r[31:0];
    brc  = (op == 5'd2) || (op == 5'd7) || (op == 5'd10);
    ill  = (op == 5'd13) || (op == 5'd14) || (op == 5'd15);
    wcls = !brc && !ill;
    cv   = (op == 5'd0) || (op == 5'd1) || (op == 5'd3);
    trap = 1'b0;
`ifdef ALU_OVF_TRAP_EN
    trap = wcls && r[34];
`endif
    e_wr  = wcls && !trap && (rd != 5'd0);
    e_ill = ill || trap;
    e_br  = brc && r[32];
    f_n   = flags_m;
    if (brc) f_n[0] = r[32];
    if (wcls) begin
      f_n[0] = (res == 32'd0);
      if (cv) f_n[2:1] = r[34:33];
    end
    tgt = pc + {{16{i16[15]}}, i16};

    w = 0;
    while ((instr_ready !== 1'b1) && (w < 20)) begin
      @(negedge clock);
      w++;
    end
    check_eq("ready_before_issue", 32'(instr_ready), 32'd1);
    instr = ins; pc_in = pc; instr_valid = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clock);
      if (k == 1) begin
        if (noise) instr = $urandom;
        else instr_valid = 1'b0;
      end
      if (k == LAT + 2) begin
        check_eq("wb_wr_en", 32'(wr_en), 32'(e_wr));
        check_eq("wb_br_taken", 32'(br_taken), 32'(e_br));
        check_eq("wb_illegal", 32'(illegal_op), 32'(e_ill));
        if (e_wr) begin
          check_eq("wb_addr", 32'(wr_addr), 32'(rd));
          check_eq("wb_data", wr_data, res);
        end
        if (e_br) check_eq("br_target", br_target, tgt);
      end else begin
        check_eq("no_strobe", {29'd0, wr_en, br_taken, illegal_op}, 32'd0);
      end
      if (k == 2) begin
        check_eq("exec_alu_a", alu_a, a);
        check_eq("exec_alu_b", alu_b, b);
        check_eq("exec_opcode", 32'(alu_opcode), 32'(op));
        instr_valid = 1'b0;
      end
      if (k == LAT + 3) begin
        check_eq("ready_after", 32'(instr_ready), 32'd1);
        check_eq("flags", 32'(flags), 32'(f_n));
      end else begin
        check_eq("busy", 32'(instr_ready), 32'd0);
      end
    end
    if (e_wr) rf_m[rd] = res;
    flags_m = f_n;
  endtask

  initial begin
    logic [31:0] ins;
    reset_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; pc_in = 32'd0;
    flags_m = 3'd0;
    for (int i = 0; i < 32; i++) rf_m[i] = init_val(5'(i));
    repeat (2) @(negedge clock);
    check_eq("rst_ready", 32'(instr_ready), 32'd1);
    check_eq("rst_flags", 32'(flags), 32'd0);
    check_eq("rst_strobes", {29'd0, wr_en, br_taken, illegal_op}, 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_alu_b", alu_b, 32'd0);
    check_eq("rst_opcode", 32'(alu_opcode), 32'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_br_target", br_target, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    do_instr({5'd0, 1'b0, 5'd3, 5'd1, 5'd2, 11'd0}, 32'h0, 1'b0);
    check_eq("add_r3", rf_rd(5'd3), 32'd12);
    check_eq("add_flags", 32'(flags), 32'd0);
    do_instr({5'd0, 1'b1, 5'd4, 5'd5, 16'hFFFF}, 32'h4, 1'b0);
    check_eq("zero_flags", 32'(flags), 32'b011);
    do_instr({5'd21, 1'b0, 5'd8, 5'd1, 5'd2, 11'd0}, 32'h8, 1'b0);
    check_eq("cv_hold", 32'(flags[2:1]), 32'b01);
    do_instr({5'd2, 1'b0, 5'd11, 5'd9, 16'h4810}, 32'h100, 1'b1);
    do_instr({5'd14, 1'b0, 5'd3, 5'd1, 5'd2, 11'd0}, 32'h10, 1'b0);
    check_eq("illegal_r3", rf_rd(5'd3), 32'd12);
    do_instr({5'd0, 1'b0, 5'd0, 5'd1, 5'd2, 11'd0}, 32'h14, 1'b0);
    do_instr({5'd0, 1'b1, 5'd7, 5'd6, 16'h0001}, 32'h18, 1'b0);
    do_instr({5'd10, 1'b0, 5'd12, 5'd1, 16'h0020}, 32'hFFFF_FFF0, 1'b0);
    do_instr({5'd7, 1'b0, 5'd1, 5'd9, 16'h4800}, 32'h20, 1'b0);

    for (int n = 0; n < 150; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[15:11] = ins[20:16];
      do_instr(ins, $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of EXEC drops the instruction.
    instr = {5'd0, 1'b0, 5'd13, 5'd1, 5'd2, 11'd0};
    instr_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      instr_valid = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check_eq("midrst_ready", 32'(instr_ready), 32'd1);
    check_eq("midrst_flags", 32'(flags), 32'd0);
    flags_m = 3'd0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check_eq("midrst_quiet", {29'd0, wr_en, br_taken, illegal_op}, 32'd0);
    end
    do_instr({5'd1, 1'b0, 5'd14, 5'd1, 5'd2, 11'd0}, 32'h40, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
